// File: rtl/int_scheduler_if.sv
// Register bus between the CPU and int_scheduler: select, write strobe,
// word index, write data and combinational read data.
interface int_scheduler_if;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, we, addr, wdata, input rdata);
    modport slave  (input sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/int_scheduler.sv
// Six-source interrupt scheduler: per-source edge/level pending, fixed priority
// (bit 0 highest), ACTIVE/INSERVICE handshake with the CPU. Define IRQ_SYNC_EN
// to put a 2-flop synchroniser in front of the sources.

module int_pend_bit (
    input  logic clk,
    input  logic reset,
    input  logic samp,
    input  logic mode,
    input  logic clr,
    output logic pend
);
    logic prev;

    // Edge mode: a rising sample beats a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= 1'b0;
            pend <= 1'b0;
        end else begin
            prev <= samp;
            if (mode) pend <= (samp & ~prev) | (pend & ~clr);
            else      pend <= samp;
        end
    end
endmodule

module int_scheduler (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        irq_in,
    input  logic              int_ack,
    int_scheduler_if.slave    bus,
    output logic [5:0]        HWInt
);
    localparam int NSRC = 6;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ACTIVE    = 2'd1;
    localparam logic [1:0] S_INSERVICE = 2'd2;

    logic [NSRC-1:0] enable, mode, pend, samp, cand, clr;
    logic [1:0]      state, state_nxt;
    logic [2:0]      grant_id, grant_nxt, winner;
    logic            wr, eoi, w1c, grant_valid, any_cand;
    logic [31:0]     rdata;
    logic [25:0]     unused_wdata;

`ifdef IRQ_SYNC_EN
    logic [NSRC-1:0] sync1, sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end
    assign samp = sync2;
`else
    assign samp = irq_in;
`endif

    assign wr           = bus.sel & bus.we;
    assign eoi          = wr & (bus.addr == 2'd3);
    assign w1c          = wr & (bus.addr == 2'd2);
    assign unused_wdata = bus.wdata[31:6];

    // Scheduling always sees the pre-write ENABLE/PEND.
    assign cand     = pend & enable;
    assign any_cand = |cand;

    always_comb begin
        winner = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (cand[i]) winner = 3'(i);
    end

    always_comb begin
        clr = w1c ? bus.wdata[NSRC-1:0] : '0;
        if (eoi && state == S_INSERVICE) clr = clr | (6'b1 << grant_id);
    end

    genvar g;
    generate
        for (g = 0; g < NSRC; g++) begin : g_src
            int_pend_bit u_pend (
                .clk   (clk),
                .reset (reset),
                .samp  (samp[g]),
                .mode  (mode[g]),
                .clr   (clr[g]),
                .pend  (pend[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable <= '0;
            mode   <= '0;
        end else if (wr) begin
            if (bus.addr == 2'd0) enable <= bus.wdata[NSRC-1:0];
            if (bus.addr == 2'd1) mode   <= bus.wdata[NSRC-1:0];
        end
    end

    // int_ack outranks preemption; EOI only matters in service.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        case (state)
            S_IDLE: begin
                if (any_cand) begin
                    state_nxt = S_ACTIVE;
                    grant_nxt = winner;
                end
            end
            S_ACTIVE: begin
                if (int_ack)        state_nxt = S_INSERVICE;
                else if (!any_cand) state_nxt = S_IDLE;
                else                grant_nxt = winner;
            end
            S_INSERVICE: begin
                if (eoi) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            grant_id <= 3'd0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
        end
    end

    assign grant_valid = (state == S_ACTIVE) || (state == S_INSERVICE);
    assign HWInt       = (state == S_ACTIVE) ? (6'b1 << grant_id) : 6'b0;

    always_comb begin
        rdata = '0;
        case (bus.addr)
            2'd0: rdata[NSRC-1:0] = enable;
            2'd1: rdata[NSRC-1:0] = mode;
            2'd2: rdata[NSRC-1:0] = pend;
            2'd3: rdata[5:0]      = {state, grant_valid, grant_id};
            default: rdata = '0;
        endcase
    end
    assign bus.rdata = rdata;
endmodule

// File: tb/tb_int_scheduler.sv
// Bench for int_scheduler: directed vector tables for the scheduling corner
// cases, then random traffic checked against a cycle reference model.
module tb_int_scheduler;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] irq_in;
    logic       int_ack;
    logic [5:0] HWInt;

    int_scheduler_if bus_if ();

    int_scheduler dut (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .int_ack (int_ack),
        .bus     (bus_if),
        .HWInt   (HWInt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  irq;
        logic        ack;
        logic        wr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp_rd;
        logic [5:0]  exp_hw;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: registers as plain vectors, state as an integer.
    logic [5:0] m_en, m_mode, m_pend, m_prev, m_s1, m_s2;
    int         m_st, m_grant;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_en = '0; m_mode = '0; m_pend = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
        m_st = 0; m_grant = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            2'd0: r = {26'd0, m_en};
            2'd1: r = {26'd0, m_mode};
            2'd2: r = {26'd0, m_pend};
            default: r = m_st * 16 + ((m_st != 0) ? 8 : 0) + m_grant;
        endcase
        return r;
    endfunction

    function automatic logic [5:0] m_hw();
        logic [5:0] h;
        h = '0;
        if (m_st == 1) h[m_grant] = 1'b1;
        return h;
    endfunction

    task automatic model_step();
        logic [5:0] samp, cand, npend;
        int win, nst, ngr;
        bit wr, eoi, rise, clr;
`ifdef IRQ_SYNC_EN
        samp = m_s2;
`else
        samp = irq_in;
`endif
        cand = m_pend & m_en;
        win = -1;
        for (int i = 5; i >= 0; i--) if (cand[i]) win = i;
        wr  = bus_if.sel && bus_if.we;
        eoi = wr && bus_if.addr == 2'd3;
        for (int i = 0; i < 6; i++) begin
            if (!m_mode[i]) npend[i] = samp[i];
            else begin
                rise = samp[i] && !m_prev[i];
                clr  = (wr && bus_if.addr == 2'd2 && bus_if.wdata[i]) ||
                       (eoi && m_st == 2 && m_grant == i);
                npend[i] = rise || (m_pend[i] && !clr);
            end
        end
        nst = m_st; ngr = m_grant;
        if (m_st == 0) begin
            if (win >= 0) begin nst = 1; ngr = win; end
        end else if (m_st == 1) begin
            if (int_ack) nst = 2;
            else if (win < 0) nst = 0;
            else ngr = win;
        end else if (eoi) nst = 0;
        if (wr && bus_if.addr == 2'd0) m_en   = bus_if.wdata[5:0];
        if (wr && bus_if.addr == 2'd1) m_mode = bus_if.wdata[5:0];
        m_s2 = m_s1; m_s1 = irq_in; m_prev = samp;
        m_pend = npend; m_st = nst; m_grant = ngr;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [5:0] irq, input logic ack, input logic wr,
                                input logic [1:0] waddr, input logic [31:0] wdata,
                                input logic [1:0] raddr, input logic [31:0] exp_rd,
                                input logic [5:0] exp_hw);
        vec_t v;
        v.irq = irq; v.ack = ack; v.wr = wr; v.waddr = waddr; v.wdata = wdata;
        v.raddr = raddr; v.exp_rd = exp_rd; v.exp_hw = exp_hw;
        return v;
    endfunction

    task automatic apply(input string tag, input vec_t v);
        irq_in = v.irq; int_ack = v.ack;
        bus_if.sel = v.wr; bus_if.we = v.wr; bus_if.addr = v.waddr; bus_if.wdata = v.wdata;
        tick();
        int_ack = 1'b0; bus_if.sel = 1'b0; bus_if.we = 1'b0; bus_if.addr = v.raddr;
        #1;
        check($sformatf("%s rdata[a%0d]", tag, v.raddr), bus_if.rdata, v.exp_rd);
        check($sformatf("%s hwint", tag), {26'd0, HWInt}, {26'd0, v.exp_hw});
    endtask

    // Asserts reset between edges and checks the asynchronous clear.
    task automatic reset_phase(input string tag);
        reset = 1'b1;
        model_reset();
        for (int a = 0; a < 4; a++) begin
            bus_if.addr = 2'(a);
            #1;
            check($sformatf("%s rst rdata[a%0d]", tag, a), bus_if.rdata, 32'd0);
        end
        check($sformatf("%s rst hwint", tag), {26'd0, HWInt}, 32'd0);
        irq_in = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    vec_t tbl[$];
    vec_t lvl[$];

    initial begin
        reset = 1'b1; irq_in = '0; int_ack = 1'b0;
        bus_if.sel = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
        @(posedge clk);
        #1;
        reset_phase("init");

`ifndef IRQ_SYNC_EN
        tbl.push_back(mk(6'h00, 0, 1, 0, 32'h3F, 0, 32'h3F, 6'h00));
        tbl.push_back(mk(6'h00, 0, 1, 1, 32'h3F, 1, 32'h3F, 6'h00));
        tbl.push_back(mk(6'h08, 0, 0, 0, 32'h00, 2, 32'h08, 6'h00));
        tbl.push_back(mk(6'h08, 0, 0, 0, 32'h00, 3, 32'h1B, 6'h08));
        tbl.push_back(mk(6'h0A, 0, 0, 0, 32'h00, 2, 32'h0A, 6'h08));
        tbl.push_back(mk(6'h0A, 0, 0, 0, 32'h00, 3, 32'h19, 6'h02));
        tbl.push_back(mk(6'h0A, 1, 0, 0, 32'h00, 3, 32'h29, 6'h00));
        tbl.push_back(mk(6'h0A, 0, 1, 3, 32'h00, 2, 32'h08, 6'h00));
        tbl.push_back(mk(6'h0A, 0, 0, 0, 32'h00, 3, 32'h1B, 6'h08));
        tbl.push_back(mk(6'h0A, 0, 1, 3, 32'h00, 3, 32'h1B, 6'h08));
        tbl.push_back(mk(6'h0A, 0, 1, 2, 32'h08, 2, 32'h00, 6'h08));
        tbl.push_back(mk(6'h0A, 0, 0, 0, 32'h00, 3, 32'h03, 6'h00));
        tbl.push_back(mk(6'h02, 1, 1, 3, 32'h00, 3, 32'h03, 6'h00));
        tbl.push_back(mk(6'h0A, 0, 1, 2, 32'h08, 2, 32'h08, 6'h00));
        tbl.push_back(mk(6'h0A, 0, 0, 0, 32'h00, 3, 32'h1B, 6'h08));
        tbl.push_back(mk(6'h0A, 1, 0, 0, 32'h00, 3, 32'h2B, 6'h00));
        foreach (tbl[i]) apply($sformatf("edge%0d", i), tbl[i]);
        reset_phase("inservice");

        lvl.push_back(mk(6'h00, 0, 1, 0, 32'h01, 0, 32'h01, 6'h00));
        lvl.push_back(mk(6'h01, 0, 0, 0, 32'h00, 2, 32'h01, 6'h00));
        lvl.push_back(mk(6'h01, 0, 1, 2, 32'h01, 2, 32'h01, 6'h01));
        lvl.push_back(mk(6'h01, 0, 0, 0, 32'h00, 3, 32'h18, 6'h01));
        lvl.push_back(mk(6'h00, 0, 0, 0, 32'h00, 2, 32'h00, 6'h01));
        lvl.push_back(mk(6'h00, 0, 0, 0, 32'h00, 3, 32'h00, 6'h00));
        foreach (lvl[i]) apply($sformatf("level%0d", i), lvl[i]);
`else
        tbl.push_back(mk(6'h00, 0, 1, 0, 32'h3F, 0, 32'h3F, 6'h00));
        tbl.push_back(mk(6'h00, 0, 1, 1, 32'h3F, 1, 32'h3F, 6'h00));
        tbl.push_back(mk(6'h08, 0, 0, 0, 32'h00, 2, 32'h00, 6'h00));
        tbl.push_back(mk(6'h08, 0, 0, 0, 32'h00, 2, 32'h00, 6'h00));
        tbl.push_back(mk(6'h08, 0, 0, 0, 32'h00, 2, 32'h08, 6'h00));
        tbl.push_back(mk(6'h08, 0, 0, 0, 32'h00, 3, 32'h1B, 6'h08));
        foreach (tbl[i]) apply($sformatf("sync%0d", i), tbl[i]);
`endif
        reset_phase("pre-random");

        for (int c = 0; c < 3000; c++) begin
            logic [1:0] ra;
            for (int b = 0; b < 6; b++)
                if ($urandom_range(7) == 0) irq_in[b] = ~irq_in[b];
            int_ack = ($urandom_range(5) == 0);
            bus_if.sel = ($urandom_range(5) == 0);
            bus_if.we = bus_if.sel;
            bus_if.addr = 2'($urandom_range(3));
            bus_if.wdata = $urandom;
            tick();
            int_ack = 1'b0; bus_if.sel = 1'b0; bus_if.we = 1'b0;
            ra = 2'($urandom_range(3));
            bus_if.addr = ra;
            #1;
            check($sformatf("rand%0d rdata[a%0d]", c, ra), bus_if.rdata, m_read(ra));
            check($sformatf("rand%0d hwint", c), {26'd0, HWInt}, {26'd0, m_hw()});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
